// File: rtl/stage2_frame_sched_if.sv
// Bus bundle between the frame sequencer, the feature-map RAM read port and
// the stage-2 CNN core.
//   rd_en / rd_addr   : RAM read strobe and raster address (sequencer -> RAM)
//   rd_data           : RAM read data, valid RD_LAT cycles after rd_en (RAM -> sequencer)
//   core_reset_n      : core counter re-align, low for one cycle per frame start
//   core_valid        : core input valid
//   core_fmap         : core input feature word (RAM data passed straight through)
//   core_ot_valid     : core output valid (core -> sequencer)
// master = sequencer side, slave = RAM/core side.
interface stage2_frame_sched_if #(
  parameter int CI  = 3,
  parameter int IBW = 20,
  parameter int AW  = 8
);
  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic [CI*IBW-1:0] rd_data;
  logic              core_reset_n;
  logic              core_valid;
  logic [CI*IBW-1:0] core_fmap;
  logic              core_ot_valid;

  modport master (
    output rd_en, rd_addr, core_reset_n, core_valid, core_fmap,
    input  rd_data, core_ot_valid
  );

  modport slave (
    input  rd_en, rd_addr, core_reset_n, core_valid, core_fmap,
    output rd_data, core_ot_valid
  );
endinterface

// File: rtl/stage2_frame_sched.sv
// Frame-level sequencer feeding stage2_cnn_core. Reads one pooled ROW x COL
// frame from the feature-map RAM in raster order, forwards it to the core,
// re-aligns the core at frame start, counts core outputs and reports frame
// completion and errors.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   i_start      : start one frame (taken only in IDLE)
//   i_hold       : pause pixel issue this cycle
//   o_busy       : high while streaming or draining
//   o_done       : one-cycle pulse at end of frame (normal or timeout)
//   o_err        : sticky drain-timeout / output-overflow flag, cleared on start
//   o_out_cnt    : core outputs seen in the current frame (saturates at N_OUT)
//   io_bus       : RAM read port and core interface (master side)
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | waiting for i_start
// STREAM | issuing one RAM read per non-held cycle, raster order
// DRAIN  | no reads; waiting for all core outputs or the timeout
// DONE   | one-cycle done pulse, back to IDLE
module stage2_frame_sched #(
  parameter int COL       = 12,
  parameter int ROW       = 12,
  parameter int KX        = 5,
  parameter int KY        = 5,
  parameter int CI        = 3,
  parameter int IBW       = 20,
  parameter int RD_LAT    = 1,
  parameter int DRAIN_MAX = 16,
  parameter int AW        = $clog2(ROW*COL)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_start,
  input  logic                 i_hold,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err,
  output logic [6:0]           o_out_cnt,
  stage2_frame_sched_if.master io_bus
);

  localparam int N_PIX = ROW * COL;
  localparam int N_OUT = (ROW - KY + 1) * (COL - KX + 1);
  localparam int DW    = $clog2(DRAIN_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [AW-1:0]     r_pix;
  logic [RD_LAT-1:0] r_pipe;
  logic [6:0]        r_out_cnt;
  logic              r_err;
  logic [DW-1:0]     r_drain_cnt;

  logic w_start;
  logic w_rd_en;
  logic w_pipe_empty;
  logic w_last_pix;
  logic w_cnt_full;
  logic w_timeout;

  assign w_start      = (r_state == S_IDLE) && i_start;
  // Reset gates the strobe so an aborted frame issues nothing in the reset cycle.
  assign w_rd_en      = (r_state == S_STREAM) && !i_hold && !reset;
  assign w_pipe_empty = (r_pipe == '0);
  assign w_last_pix   = (r_pix == AW'(N_PIX - 1));
  assign w_cnt_full   = (r_out_cnt == 7'(N_OUT));

  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_next = S_STREAM;
      end
      S_STREAM: begin
        if (!i_hold && w_last_pix) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        // A complete frame wins over a timeout landing in the same cycle.
        if (w_cnt_full && w_pipe_empty) begin
          w_next = S_DONE;
        end else if (r_drain_cnt == DW'(1)) begin
          w_next    = S_DONE;
          w_timeout = 1'b1;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_pix       <= '0;
      r_pipe      <= '0;
      r_out_cnt   <= '0;
      r_err       <= 1'b0;
      r_drain_cnt <= '0;
    end else begin
      r_state <= w_next;

      // Read-latency pipe shifts every cycle so data in flight still lands under hold.
      r_pipe[0] <= w_rd_en;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end

      if (w_start) begin
        r_pix     <= '0;
        r_out_cnt <= '0;
        r_err     <= 1'b0;
      end else begin
        if (w_rd_en) r_pix <= r_pix + 1'b1;
        if (io_bus.core_ot_valid && (r_state != S_IDLE)) begin
          if (w_cnt_full) r_err <= 1'b1;
          else            r_out_cnt <= r_out_cnt + 1'b1;
        end
        if (w_timeout) r_err <= 1'b1;
      end

      // Drain timer: loaded on entry, terminal count at 1 bounds DRAIN to DRAIN_MAX cycles.
      if ((r_state == S_STREAM) && (w_next == S_DRAIN)) begin
        r_drain_cnt <= DW'(DRAIN_MAX);
      end else if (r_state == S_DRAIN) begin
        r_drain_cnt <= r_drain_cnt - 1'b1;
      end
    end
  end

  assign io_bus.rd_en        = w_rd_en;
  assign io_bus.rd_addr      = r_pix;
  assign io_bus.core_reset_n = !(reset || w_start);
  assign io_bus.core_valid   = r_pipe[RD_LAT-1];
  assign io_bus.core_fmap    = io_bus.rd_data;

  assign o_busy    = (r_state == S_STREAM) || (r_state == S_DRAIN);
  assign o_done    = (r_state == S_DONE);
  assign o_err     = r_err;
  assign o_out_cnt = r_out_cnt;

endmodule

// File: tb/tb_stage2_frame_sched.sv
// Bench for stage2_frame_sched: vector table for the start/hold/reset
// sequencing, hand-written frame scenarios, and randomized frames, all
// checked cycle by cycle against a frame-level reference model.
module tb_stage2_frame_sched;
  localparam int COL = 12, ROW = 12, KX = 5, KY = 5, CI = 3, IBW = 20;
  localparam int RD_LAT = 1, DRAIN_MAX = 16, AW = 8;
  localparam int N_PIX = ROW * COL;
  localparam int N_OUT = (ROW - KY + 1) * (COL - KX + 1);
  localparam int FW = CI * IBW;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic i_start = 1'b0;
  logic i_hold = 1'b0;
  logic o_busy, o_done, o_err;
  logic [6:0] o_out_cnt;

  stage2_frame_sched_if #(.CI(CI), .IBW(IBW), .AW(AW)) bus ();

  stage2_frame_sched #(
    .COL(COL), .ROW(ROW), .KX(KX), .KY(KY), .CI(CI), .IBW(IBW),
    .RD_LAT(RD_LAT), .DRAIN_MAX(DRAIN_MAX), .AW(AW)
  ) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_hold(i_hold),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_out_cnt(o_out_cnt),
    .io_bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [FW-1:0] ram_f(input int a);
    ram_f = {IBW'(a * 3 + 1), IBW'(a ^ 32'h5A5), IBW'(a + 7)};
  endfunction

  // RAM with one cycle of read latency.
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= ram_f(int'(bus.rd_addr));
  end

  // Core stand-in: one output per valid window position, one cycle later.
  // core_mode 1 drops the last output, core_mode 2 adds a spurious extra one.
  int   core_mode = 0;
  int   r_k = 0;
  logic r_extra = 1'b0;
  always @(posedge clk) begin
    if (reset || !bus.core_reset_n) begin
      r_k <= 0;
      r_extra <= 1'b0;
      bus.core_ot_valid <= 1'b0;
    end else begin
      bus.core_ot_valid <= r_extra;
      r_extra <= 1'b0;
      if (bus.core_valid) begin
        r_k <= r_k + 1;
        if ((r_k / COL >= KY - 1) && (r_k % COL >= KX - 1) &&
            !(core_mode == 1 && r_k == N_PIX - 1))
          bus.core_ot_valid <= 1'b1;
        if (core_mode == 2 && r_k == N_PIX - 1) r_extra <= 1'b1;
      end
    end
  end

  int n_err = 0;
  int n_checks = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Frame-level reference model.
  bit m_active = 0, m_donecyc = 0, m_err = 0;
  int m_issued = 0, m_outs = 0, m_drain = 0;
  bit m_hv[$];
  int m_ha[$];

  logic s_rd, s_cv, s_rstn, s_busy, s_done, s_err;
  logic [AW-1:0] s_addr;
  logic [FW-1:0] s_fm;
  logic [6:0] s_cnt;

  task automatic model_clear();
    m_active = 0; m_donecyc = 0; m_err = 0;
    m_issued = 0; m_outs = 0; m_drain = 0;
    m_hv.delete(); m_ha.delete();
    for (int i = 0; i < RD_LAT; i++) begin
      m_hv.push_back(1'b0);
      m_ha.push_back(0);
    end
  endtask

  // One clock cycle: inputs already applied, sample at negedge, check, advance model.
  task automatic cyc();
    bit idle, e_rstn, e_rd, e_cv, fin, empty;
    int e_addr;
    @(negedge clk);
    idle   = !m_active && !m_donecyc;
    e_rstn = !(reset || (idle && i_start));
    e_rd   = !reset && m_active && (m_issued < N_PIX) && !i_hold;
    e_cv   = m_hv[0];
    e_addr = m_ha[0];
    s_rd = bus.rd_en; s_addr = bus.rd_addr; s_cv = bus.core_valid; s_fm = bus.core_fmap;
    s_rstn = bus.core_reset_n; s_busy = o_busy; s_done = o_done; s_err = o_err; s_cnt = o_out_cnt;
    chk("core_reset_n", s_rstn, e_rstn);
    chk("rd_en", s_rd, e_rd);
    if (!reset) begin
      chk("rd_addr", s_addr, m_issued);
      chk("core_valid", s_cv, e_cv);
      if (e_cv) chk("core_fmap", s_fm, ram_f(e_addr));
      chk("busy", s_busy, m_active);
      chk("done", s_done, m_donecyc);
      chk("err", s_err, m_err);
      chk("out_cnt", s_cnt, m_outs);
    end
    if (reset) begin
      model_clear();
    end else begin
      fin = 0;
      if (m_active && m_issued == N_PIX) begin
        empty = 1;
        foreach (m_hv[i]) if (m_hv[i]) empty = 0;
        if (m_outs == N_OUT && empty) fin = 1;
        else if (m_drain == DRAIN_MAX - 1) begin fin = 1; m_err = 1; end
        m_drain++;
      end
      if ((m_active || m_donecyc) && bus.core_ot_valid) begin
        if (m_outs == N_OUT) m_err = 1;
        else m_outs++;
      end
      void'(m_hv.pop_front()); m_hv.push_back(e_rd);
      void'(m_ha.pop_front()); m_ha.push_back(m_issued);
      if (e_rd) m_issued++;
      if (fin) m_active = 0;
      m_donecyc = fin;
      if (idle && i_start) begin
        m_active = 1; m_issued = 0; m_outs = 0; m_err = 0; m_drain = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1; i_start = 0; i_hold = 0;
    cyc(); cyc();
    reset = 0;
  endtask

  int f_done, f_rd, f_cv, f_ot, f_rstn_low, f_last_rd, f_done_cyc, f_cv_post, f_done_post;

  // pat 1: hold 3 cycles at pix 30 and 1 cycle at pix 143; otherwise random holds.
  // noise: pulse i_start on odd cycles until done; rst_at>=0: reset when that pixel is next.
  task automatic run_frame(input int pat, input int hold_pct, input bit noise,
                           input int rst_at, input int tail);
    int i, h30, h143, post;
    bit rst_done, ended;
    f_done = 0; f_rd = 0; f_cv = 0; f_ot = 0; f_rstn_low = 0; f_last_rd = 0;
    f_done_cyc = 0; f_cv_post = 0; f_done_post = 0;
    i = 0; h30 = 0; h143 = 0; post = 0; rst_done = 0; ended = 0;
    while (!ended && i < 600) begin
      i_start = !rst_done && (f_done == 0) && ((i == 0) || (noise && (i % 2 == 1)));
      i_hold = 1'b0;
      if (pat == 1) begin
        if (m_active && m_issued == 30 && h30 < 3) begin i_hold = 1'b1; h30++; end
        else if (m_active && m_issued == N_PIX - 1 && h143 < 1) begin i_hold = 1'b1; h143++; end
      end else begin
        i_hold = ($urandom_range(0, 99) < hold_pct);
      end
      reset = !rst_done && (rst_at >= 0) && m_active && (m_issued == rst_at);
      cyc();
      if (reset) begin
        rst_done = 1;
      end else if (rst_done) begin
        post++;
        if (s_cv) f_cv_post++;
        if (s_done) f_done_post++;
        if (post >= 6) ended = 1;
      end else begin
        if (s_rd) begin f_rd++; f_last_rd = i; end
        if (s_cv) f_cv++;
        if (bus.core_ot_valid) f_ot++;
        if (!s_rstn) f_rstn_low++;
        if (s_done) begin
          f_done++;
          if (f_done == 1) f_done_cyc = i;
        end
        if (f_done > 0 && (i - f_done_cyc) >= tail) ended = 1;
      end
      i++;
    end
    reset = 0; i_start = 0; i_hold = 0;
    if (!ended) begin
      n_checks++; n_err++;
      $display("FAIL frame_budget: actual=no frame end required=end within %0d cycles", i);
    end
  endtask

  typedef struct packed {
    logic rst, st, hold, chk, busy, rstn, rd, cv;
    logic [7:0] addr;
  } vec_t;
  vec_t tbl [0:10];

  initial begin
    //          rst st hold chk busy rstn rd cv addr
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd2};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd3};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};

    model_clear();
    pulse_reset();

    // Vector table: start, hold, ignored start, mid-frame reset.
    for (int v = 0; v <= 10; v++) begin
      reset = tbl[v].rst; i_start = tbl[v].st; i_hold = tbl[v].hold;
      cyc();
      if (tbl[v].chk) begin
        chk($sformatf("vec%0d_busy", v), s_busy, tbl[v].busy);
        chk($sformatf("vec%0d_rstn", v), s_rstn, tbl[v].rstn);
        chk($sformatf("vec%0d_rd_en", v), s_rd, tbl[v].rd);
        chk($sformatf("vec%0d_cv", v), s_cv, tbl[v].cv);
        chk($sformatf("vec%0d_addr", v), s_addr, tbl[v].addr);
        chk($sformatf("vec%0d_done", v), s_done, 0);
      end
    end
    reset = 0; i_start = 0; i_hold = 0;

    // Full frame, no holds.
    pulse_reset(); core_mode = 0;
    run_frame(0, 0, 0, -1, 4);
    chk("t1_rd_count", f_rd, N_PIX);
    chk("t1_last_rd_cycle", f_last_rd, N_PIX);
    chk("t1_cv_count", f_cv, N_PIX);
    chk("t1_core_outs", f_ot, N_OUT);
    chk("t1_done_pulses", f_done, 1);
    chk("t1_core_reset_pulses", f_rstn_low, 1);
    chk("t1_out_cnt", o_out_cnt, N_OUT);
    chk("t1_err", o_err, 0);

    // Holds at pix 30 (3 cycles) and 143 (1 cycle).
    pulse_reset(); core_mode = 0;
    run_frame(1, 0, 0, -1, 2);
    chk("t2_rd_count", f_rd, N_PIX);
    chk("t2_last_rd_cycle", f_last_rd, N_PIX + 4);
    chk("t2_cv_count", f_cv, N_PIX);
    chk("t2_out_cnt", o_out_cnt, N_OUT);
    chk("t2_done_pulses", f_done, 1);

    // Start pulses while busy are ignored.
    pulse_reset(); core_mode = 0;
    run_frame(0, 10, 1, -1, 4);
    chk("t3_done_pulses", f_done, 1);
    chk("t3_core_reset_pulses", f_rstn_low, 1);
    chk("t3_rd_count", f_rd, N_PIX);
    chk("t3_out_cnt", o_out_cnt, N_OUT);

    // Missing output -> drain timeout.
    pulse_reset(); core_mode = 1;
    run_frame(0, 0, 0, -1, 2);
    chk("t4_done_pulses", f_done, 1);
    chk("t4_drain_length", f_done_cyc - f_last_rd, DRAIN_MAX + 1);
    chk("t4_err", o_err, 1);
    chk("t4_out_cnt", o_out_cnt, N_OUT - 1);

    // Spurious 65th output -> overflow error, count saturates.
    pulse_reset(); core_mode = 2;
    run_frame(0, 0, 0, -1, 2);
    chk("t4b_err", o_err, 1);
    chk("t4b_out_cnt", o_out_cnt, N_OUT);

    // Reset at pix 70, then a clean frame.
    pulse_reset(); core_mode = 0;
    run_frame(0, 0, 0, 70, 0);
    chk("t5_rd_before_reset", f_rd, 70);
    chk("t5_cv_after_reset", f_cv_post, 0);
    chk("t5_done_after_reset", f_done_post + f_done, 0);
    run_frame(0, 0, 0, -1, 0);
    chk("t5_clean_out_cnt", o_out_cnt, N_OUT);
    chk("t5_clean_err", o_err, 0);
    chk("t5_clean_done", f_done, 1);

    // Back-to-back frames.
    pulse_reset(); core_mode = 0;
    for (int k = 0; k < 2; k++) begin
      run_frame(0, 0, 0, -1, 0);
      chk($sformatf("t6_done%0d", k), f_done, 1);
      chk($sformatf("t6_rd%0d", k), f_rd, N_PIX);
      chk($sformatf("t6_core_reset%0d", k), f_rstn_low, 1);
      chk($sformatf("t6_out_cnt%0d", k), o_out_cnt, N_OUT);
    end

    // Randomized frames against the model.
    for (int r = 0; r < 8; r++) begin
      int sel;
      pulse_reset();
      sel = $urandom_range(0, 4);
      core_mode = (sel == 0) ? 1 : (sel == 1) ? 2 : 0;
      run_frame(0, $urandom_range(0, 40), bit'($urandom_range(0, 1)),
                ($urandom_range(0, 4) == 0) ? $urandom_range(1, N_PIX - 1) : -1, 3);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
